// File: rtl/ter_pkg.sv
// Ternary (Z3) coefficient types and arithmetic shared by the phi1 stream path.
package ter_pkg;

  typedef logic [1:0] ter_t;

  localparam ter_t TER_ZERO = 2'b00;
  localparam ter_t TER_POS  = 2'b01;
  localparam ter_t TER_NEG  = 2'b10;

  typedef enum logic {
    PHI1_DIV = 1'b0,
    PHI1_MUL = 1'b1
  } phi1_mode_e;

  // The unused code 2'b11 is read as zero.
  function automatic ter_t ter_sanitize(ter_t a);
    return (a == 2'b11) ? TER_ZERO : a;
  endfunction

  function automatic ter_t ter_neg(ter_t a);
    ter_t r;
    case (ter_sanitize(a))
      TER_POS: r = TER_NEG;
      TER_NEG: r = TER_POS;
      default: r = TER_ZERO;
    endcase
    return r;
  endfunction

  // Sum mod 3; equal non-zero operands wrap to the opposite sign.
  function automatic ter_t ter_add(ter_t a, ter_t b);
    ter_t sa;
    ter_t sb;
    ter_t r;
    sa = ter_sanitize(a);
    sb = ter_sanitize(b);
    if (sa == TER_ZERO) begin
      r = sb;
    end else if (sb == TER_ZERO) begin
      r = sa;
    end else if (sa == sb) begin
      r = ter_neg(sa);
    end else begin
      r = TER_ZERO;
    end
    return r;
  endfunction

endpackage

// File: rtl/ter_phi1_stream_if.sv
// Stream handshake bundle between the S3 reduction stage and the lift output stage.
interface ter_phi1_stream_if #(
  parameter int unsigned LANES = 2
);
  localparam int unsigned DATA_W = 2 * LANES;

  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/ter_phi1_lane.sv
// One step of the (1 - x) recurrence: prefix sum (DIV) or first difference (MUL).
module ter_phi1_lane
  import ter_pkg::*;
(
  input  phi1_mode_e mode,
  input  ter_t       a,
  input  ter_t       c_in,
  output ter_t       y,
  output ter_t       c_out
);

  ter_t a_s;

  // DIV carries the running sum forward; MUL carries the raw input forward.
  always_comb begin
    a_s   = ter_sanitize(a);
    y     = TER_ZERO;
    c_out = TER_ZERO;
    if (mode == PHI1_DIV) begin
      y     = ter_add(c_in, a_s);
      c_out = y;
    end else begin
      y     = ter_add(a_s, ter_neg(c_in));
      c_out = a_s;
    end
  end

endmodule

// File: rtl/ter_phi1_stream.sv
// Streaming multiply/divide by (1 - x) over Z3, LANES coefficients per beat.
module ter_phi1_stream
  import ter_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned N     = 700
) (
  input logic              clk,
  input logic              rst,
  ter_phi1_stream_if.slave bus
);

  localparam int unsigned BEATS  = N / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DATA_W = 2 * LANES;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [BEAT_W-1:0] beat_cnt;
  ter_t              carry;
  phi1_mode_e        mode_q;

  logic              accept;
  logic              first_beat;
  phi1_mode_e        mode_eff;
  ter_t              c_start;
  logic [DATA_W-1:0] y_beat;
  ter_t              c_next;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign first_beat   = (beat_cnt == '0);
  assign mode_eff     = first_beat ? phi1_mode_e'(bus.mode) : mode_q;
  assign c_start      = first_beat ? TER_ZERO : carry;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ter_t c_in;
    ter_t y;
    ter_t c_out;

    if (k == 0) begin : g_head
      assign c_in = c_start;
    end else begin : g_link
      assign c_in = g_lane[k-1].c_out;
    end

    ter_phi1_lane u_lane (
      .mode  (mode_eff),
      .a     (bus.in_data[2*k +: 2]),
      .c_in  (c_in),
      .y     (y),
      .c_out (c_out)
    );

    assign y_beat[2*k +: 2] = y;
  end

  assign c_next = g_lane[LANES-1].c_out;

  // Output register, frame counter, carry and mode latch; an accept overrides a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.busy      <= 1'b0;
      beat_cnt      <= '0;
      carry         <= TER_ZERO;
      mode_q        <= PHI1_DIV;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
        if (bus.out_last) begin
          bus.busy <= 1'b0;
        end
      end
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= y_beat;
        bus.busy      <= 1'b1;
        mode_q        <= mode_eff;
        if (beat_cnt == LAST_BEAT) begin
          bus.out_last <= 1'b1;
          beat_cnt     <= '0;
          carry        <= TER_ZERO;
        end else begin
          bus.out_last <= 1'b0;
          beat_cnt     <= beat_cnt + BEAT_W'(1);
          carry        <= c_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_ter_phi1_stream.sv
// Scoreboard bench: a small directed instance (LANES=2, N=4) and a random round-trip instance (LANES=4, N=700).
module tb_ter_phi1_stream;
  import ter_pkg::*;

  localparam int unsigned LA = 2;
  localparam int unsigned NA = 4;
  localparam int unsigned LB = 4;
  localparam int unsigned NB = 700;

  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] M = 2'b10;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  ter_phi1_stream_if #(.LANES(LA)) bus_a ();
  ter_phi1_stream_if #(.LANES(LB)) bus_b ();

  ter_phi1_stream #(.LANES(LA), .N(NA)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  ter_phi1_stream #(.LANES(LB), .N(NB)) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  logic [8:0] e_a;
  logic [8:0] e_b;
  int         xs[NB];
  int         ys[NB];
  logic       b_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] pk2(input logic [1:0] l0, input logic [1:0] l1);
    return {l1, l0};
  endfunction

  function automatic logic [1:0] i2t(input int v);
    logic [1:0] r;
    case (((v % 3) + 3) % 3)
      1:       r = 2'b01;
      2:       r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Scoreboard pops for the directed instance
  always @(negedge clk) begin
    if (!rst_a && bus_a.out_valid && bus_a.out_ready) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_beat", 64'(1), 64'(0));
      end else begin
        e_a = q_a.pop_front();
        check("a_data", 64'(bus_a.out_data), 64'(e_a[3:0]));
        check("a_last", 64'(bus_a.out_last), 64'(e_a[8]));
      end
    end
  end

  // Scoreboard pops for the random instance
  always @(negedge clk) begin
    if (!rst_b && bus_b.out_valid && bus_b.out_ready) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_beat", 64'(1), 64'(0));
      end else begin
        e_b = q_b.pop_front();
        check("b_data", 64'(bus_b.out_data), 64'(e_b[7:0]));
        check("b_last", 64'(bus_b.out_last), 64'(e_b[8]));
      end
    end
  end

  // Random downstream backpressure on the large instance
  initial begin
    bus_b.out_ready = 1'b1;
    while (!b_done) begin
      @(posedge clk);
      #1;
      bus_b.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus_b.out_ready = 1'b1;
  end

  task automatic send_a(input logic m, input logic [3:0] d, input logic [3:0] exp_d, input logic exp_l);
    int waited;
    waited = 0;
    bus_a.mode     = m;
    bus_a.in_data  = d;
    bus_a.in_valid = 1'b1;
    @(negedge clk);
    while (!bus_a.in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!bus_a.in_ready) check("a_accept_timeout", 64'(0), 64'(1));
    else q_a.push_back({exp_l, 4'b0000, exp_d});
    @(posedge clk);
    #1;
    bus_a.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic m, input logic [7:0] d, input logic [7:0] exp_d, input logic exp_l);
    int waited;
    waited = 0;
    bus_b.mode     = m;
    bus_b.in_data  = d;
    bus_b.in_valid = 1'b1;
    @(negedge clk);
    while (!bus_b.in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!bus_b.in_ready) check("b_accept_timeout", 64'(0), 64'(1));
    else q_b.push_back({exp_l, exp_d});
    @(posedge clk);
    #1;
    bus_b.in_valid = 1'b0;
  endtask

  task automatic seq_a();
    rst_a           = 1'b1;
    bus_a.in_valid  = 1'b0;
    bus_a.in_data   = '0;
    bus_a.mode      = 1'b0;
    bus_a.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("a_rst_out_valid", 64'(bus_a.out_valid), 64'(0));
    check("a_rst_out_data", 64'(bus_a.out_data), 64'(0));
    check("a_rst_out_last", 64'(bus_a.out_last), 64'(0));
    check("a_rst_busy", 64'(bus_a.busy), 64'(0));
    rst_a = 1'b0;

    // DIV basic, one-cycle latency
    send_a(1'b0, pk2(P, P), pk2(P, M), 1'b0);
    check("a_latency_valid", 64'(bus_a.out_valid), 64'(1));
    check("a_busy_set", 64'(bus_a.busy), 64'(1));
    send_a(1'b0, pk2(P, M), pk2(Z, M), 1'b1);
    @(posedge clk);
    #1;
    check("a_idle_valid", 64'(bus_a.out_valid), 64'(0));
    check("a_idle_busy", 64'(bus_a.busy), 64'(0));

    // MUL basic
    send_a(1'b1, pk2(P, P), pk2(P, Z), 1'b0);
    send_a(1'b1, pk2(P, M), pk2(Z, P), 1'b1);
    @(posedge clk);
    #1;

    // Backpressure for three cycles mid-frame
    send_a(1'b0, pk2(P, P), pk2(P, M), 1'b0);
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = pk2(P, M);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("a_bp_in_ready", 64'(bus_a.in_ready), 64'(0));
      check("a_bp_out_valid", 64'(bus_a.out_valid), 64'(1));
      check("a_bp_out_data", 64'(bus_a.out_data), 64'(pk2(P, M)));
      check("a_bp_out_last", 64'(bus_a.out_last), 64'(0));
    end
    @(posedge clk);
    #1;
    bus_a.out_ready = 1'b1;
    send_a(1'b0, pk2(P, M), pk2(Z, M), 1'b1);
    @(posedge clk);
    #1;

    // Back-to-back frames; mid-frame mode toggles are ignored
    send_a(1'b0, pk2(P, P), pk2(P, M), 1'b0);
    send_a(1'b1, pk2(P, M), pk2(Z, M), 1'b1);
    check("a_b2b_busy", 64'(bus_a.busy), 64'(1));
    send_a(1'b0, pk2(P, Z), pk2(P, P), 1'b0);
    send_a(1'b1, pk2(Z, Z), pk2(P, P), 1'b1);
    @(posedge clk);
    #1;

    // Reset mid-frame with a stalled pending output
    bus_a.out_ready = 1'b0;
    send_a(1'b0, pk2(P, P), pk2(P, M), 1'b0);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    check("a_midrst_out_valid", 64'(bus_a.out_valid), 64'(0));
    check("a_midrst_busy", 64'(bus_a.busy), 64'(0));
    check("a_midrst_pending", 64'(q_a.size()), 64'(1));
    if (q_a.size() > 0) void'(q_a.pop_back());
    bus_a.out_ready = 1'b1;

    // Fresh frame after reset, including the 2'b11 code
    send_a(1'b0, pk2(2'b11, P), pk2(Z, P), 1'b0);
    send_a(1'b0, pk2(P, Z), pk2(M, M), 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic seq_b();
    logic [7:0] d;
    logic [7:0] e;
    logic [1:0] code;
    logic       m;
    int         s;
    int         idx;
    rst_b          = 1'b1;
    bus_b.in_valid = 1'b0;
    bus_b.in_data  = '0;
    bus_b.mode     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("b_rst_out_valid", 64'(bus_b.out_valid), 64'(0));
    check("b_rst_busy", 64'(bus_b.busy), 64'(0));
    rst_b = 1'b0;

    // Each iteration: DIV frame on x, then MUL frame on the prefix sum, which must return x
    for (int f = 0; f < 100; f++) begin
      s = 0;
      for (int i = 0; i < int'(NB); i++) begin
        xs[i] = int'($urandom_range(0, 2));
        s     = (s + xs[i]) % 3;
        ys[i] = s;
      end
      for (int ph = 0; ph < 2; ph++) begin
        for (int b = 0; b < int'(NB / LB); b++) begin
          for (int l = 0; l < int'(LB); l++) begin
            idx = b * int'(LB) + l;
            if (ph == 0) begin
              code = i2t(xs[idx]);
              if (xs[idx] == 0 && $urandom_range(0, 3) == 0) code = 2'b11;
              d[2*l +: 2] = code;
              e[2*l +: 2] = i2t(ys[idx]);
            end else begin
              d[2*l +: 2] = i2t(ys[idx]);
              e[2*l +: 2] = i2t(xs[idx]);
            end
          end
          m = (b == 0) ? 1'(ph) : 1'($urandom_range(0, 1));
          send_b(m, d, e, (b == int'(NB / LB) - 1));
        end
      end
    end
    b_done = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    fork
      seq_a();
      seq_b();
    join
    for (int i = 0; i < 200 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
    #1;
    check("a_queue_drained", 64'(q_a.size()), 64'(0));
    check("b_queue_drained", 64'(q_b.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
